uart_wb_arbiter: RTL and testbench
==================================

Name: uart_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single uart_8250 slave port between two requesters, e.g. CPU core and debug/boot loader.
- Grants are round-robin and held for the whole CYC_I period, so a master's multi-beat register sequence cannot be split by the other master (DLAB set -> divisor write -> DLAB clear).
- A bus watchdog aborts a transfer that the slave never ACKs and reports an error to the owning master.

Parameters:
- TO_W, 8, width of the watchdog counter.
- TIMEOUT, 255, number of cycles with S_STB_O high and no S_ACK_I before abort. Must be >= 1 and < 2^TO_W.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  asynchronous active-low reset.
- M0_ADR_I  in  32  master 0 address.
- M0_DAT_I  in  32  master 0 write data.
- M0_DAT_O  out  32  master 0 read data.
- M0_WE_I  in  1  master 0 write enable.
- M0_SEL_I  in  4  master 0 byte select.
- M0_STB_I  in  1  master 0 strobe.
- M0_CYC_I  in  1  master 0 cycle/request.
- M0_ACK_O  out  1  master 0 acknowledge.
- M0_ERR_O  out  1  master 0 timeout error.
- M1_ADR_I, M1_DAT_I, M1_DAT_O, M1_WE_I, M1_SEL_I, M1_STB_I, M1_CYC_I, M1_ACK_O, M1_ERR_O: same widths and meaning for master 1.
- S_ADR_O  out  32  to slave ADR_I.
- S_DAT_O  out  32  to slave DAT_I.
- S_DAT_I  in  32  from slave DAT_O.
- S_WE_O  out  1  to slave WE_I.
- S_SEL_O  out  4  to slave SEL_I.
- S_STB_O  out  1  to slave STB_I.
- S_CYC_O  out  1  to slave CYC_I.
- S_ACK_I  in  1  from slave ACK_O.
- GNT_O  out  2  one-hot current owner; 00 = none.

Behaviour:
- Reset (RST_I low, async): state=IDLE, GNT_O=00, last_owner=1 (master 0 wins first tie), watchdog=0. All S_* and M*_ACK_O/M*_ERR_O/M*_DAT_O outputs are 0.
- State register: IDLE, OWN, ABORT. Owner is held in the GNT register.
- IDLE:
  - Sample M0_CYC_I and M1_CYC_I.
  - One requester: grant it.
  - Both: grant the master that is not last_owner.
  - Neither: stay in IDLE.
  - On grant, GNT_O updates at the next edge and state goes to OWN. Grant latency from CYC rise is 1 cycle.
- OWN:
  - Slave outputs are a combinational mux of the owner's ADR/DAT/WE/SEL/STB.
  - S_CYC_O = owner CYC.
  - Owner ACK_O = S_ACK_I & owner STB; owner DAT_O = S_DAT_I.
  - Non-owner ACK_O, ERR_O and DAT_O are 0.
  - Owner CYC low: at the next edge go to IDLE, set last_owner=owner and GNT_O=00. There is one idle bubble cycle between owners.
  - Non-owner CYC is ignored until the return to IDLE; no preemption.
- Watchdog (OWN only):
  - Increments each cycle with S_STB_O=1 and S_ACK_I=0.
  - Clears on S_ACK_I=1, on S_STB_O=0, or on leaving OWN.
  - When the count equals TIMEOUT-1 with no ACK, at the next edge enter ABORT.
- ABORT:
  - S_CYC_O and S_STB_O are forced to 0.
  - Owner ERR_O=1 while the owner's STB is high; owner ACK_O=0.
  - Stay until owner CYC drops, then IDLE with last_owner updated.
- Simultaneous events:
  - ACK arriving in the same cycle the count reaches TIMEOUT-1: the ACK wins, no abort.
  - Owner drops CYC in the same cycle the other master raises CYC: the other master is granted via IDLE after the bubble.
- Width rules: all buses pass through unmodified. The arbiter does no address decoding.

Test Plan:
- Reset low mid-transfer (M0 owning, S_STB_O=1) -> same-cycle S_CYC_O=0, S_STB_O=0, GNT_O=00; after release M0 wins a tie first.
- M0 only: CYC+STB, write ADR=0x0C, DAT=0x83, SEL=0001; slave ACKs at cycle 3 -> GNT_O=01 one cycle after CYC; S_* mirror M0; M0_ACK_O pulses with S_ACK_I; M1_ACK_O stays 0.
- Both CYC rise in the same cycle from reset -> GNT_O=01. M0 does 3 beats (LCR=0x83, DLL=0x1B, LCR=0x03) with M1 held requesting -> no M1 grant until M0 CYC drops; then one bubble cycle, then GNT_O=10.
- Continuous requests from both masters over 6 transactions -> grants alternate 01,10,01,10,01,10.
- M1 owns, slave never ACKs, TIMEOUT=4 -> after 4 STB cycles S_CYC_O/S_STB_O drop and M1_ERR_O=1 until M1 drops CYC; then IDLE and M0 can be granted.
- S_ACK_I on exactly the 4th waiting cycle (TIMEOUT=4) -> normal ACK, M1_ERR_O=0, no ABORT.

Source files
------------

// File: rtl/uart_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the uart_8250 slave port.
// A grant is held for the owner's whole CYC period, and a watchdog aborts a transfer the slave never ACKs.
module uart_wb_arbiter #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] M0_ADR_I,
   input  logic [31:0] M0_DAT_I,
   output logic [31:0] M0_DAT_O,
   input  logic        M0_WE_I,
   input  logic [3:0]  M0_SEL_I,
   input  logic        M0_STB_I,
   input  logic        M0_CYC_I,
   output logic        M0_ACK_O,
   output logic        M0_ERR_O,
   input  logic [31:0] M1_ADR_I,
   input  logic [31:0] M1_DAT_I,
   output logic [31:0] M1_DAT_O,
   input  logic        M1_WE_I,
   input  logic [3:0]  M1_SEL_I,
   input  logic        M1_STB_I,
   input  logic        M1_CYC_I,
   output logic        M1_ACK_O,
   output logic        M1_ERR_O,
   output logic [31:0] S_ADR_O,
   output logic [31:0] S_DAT_O,
   input  logic [31:0] S_DAT_I,
   output logic        S_WE_O,
   output logic [3:0]  S_SEL_O,
   output logic        S_STB_O,
   output logic        S_CYC_O,
   input  logic        S_ACK_I,
   output logic [1:0]  GNT_O
);
   typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

   localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic            last_q, last_d;
   logic [TO_W-1:0] wdog_q, wdog_d;

   logic            own;
   logic [31:0]     o_adr, o_dat;
   logic [3:0]      o_sel;
   logic            o_we, o_stb, o_cyc;
   logic            ack, err;

   // Owner index: 1 when master 1 holds the bus
   assign own   = gnt_q[1];
   assign o_adr = own ? M1_ADR_I : M0_ADR_I;
   assign o_dat = own ? M1_DAT_I : M0_DAT_I;
   assign o_sel = own ? M1_SEL_I : M0_SEL_I;
   assign o_we  = own ? M1_WE_I  : M0_WE_I;
   assign o_stb = own ? M1_STB_I : M0_STB_I;
   assign o_cyc = own ? M1_CYC_I : M0_CYC_I;
   assign GNT_O = gnt_q;

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wdog_d  = '0;
      case (state_q)
         IDLE: begin
            if (M0_CYC_I && M1_CYC_I) gnt_d = last_q ? 2'b01 : 2'b10;
            else if (M0_CYC_I)        gnt_d = 2'b01;
            else if (M1_CYC_I)        gnt_d = 2'b10;
            if (M0_CYC_I || M1_CYC_I) state_d = OWN;
         end
         OWN: begin
            if (!o_cyc) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               last_d  = own;
            end else if (o_stb && !S_ACK_I) begin
               // An ACK in the limit cycle takes this branch's else, so it wins
               if (wdog_q == WD_LAST) state_d = ABORT;
               else                   wdog_d  = wdog_q + TO_W'(1);
            end
         end
         ABORT: begin
            if (!o_cyc) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
               last_d  = own;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_comb begin
      S_ADR_O  = '0;
      S_DAT_O  = '0;
      S_WE_O   = 1'b0;
      S_SEL_O  = '0;
      S_STB_O  = 1'b0;
      S_CYC_O  = 1'b0;
      M0_ACK_O = 1'b0;
      M0_ERR_O = 1'b0;
      M0_DAT_O = '0;
      M1_ACK_O = 1'b0;
      M1_ERR_O = 1'b0;
      M1_DAT_O = '0;
      ack      = 1'b0;
      err      = 1'b0;
      if (state_q != IDLE) begin
         S_ADR_O = o_adr;
         S_DAT_O = o_dat;
         S_WE_O  = o_we;
         S_SEL_O = o_sel;
      end
      if (state_q == OWN) begin
         S_STB_O = o_stb;
         S_CYC_O = o_cyc;
         ack     = S_ACK_I & o_stb;
         if (own) begin
            M1_ACK_O = ack;
            M1_DAT_O = S_DAT_I;
         end else begin
            M0_ACK_O = ack;
            M0_DAT_O = S_DAT_I;
         end
      end
      if (state_q == ABORT) begin
         err = o_stb;
         if (own) M1_ERR_O = err;
         else     M0_ERR_O = err;
      end
   end
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter: reset, grant hold, round-robin, watchdog abort and ACK-at-limit.
module tb_uart_wb_arbiter;
   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic [31:0] M0_ADR_I, M0_DAT_I, M0_DAT_O;
   logic        M0_WE_I, M0_STB_I, M0_CYC_I, M0_ACK_O, M0_ERR_O;
   logic [3:0]  M0_SEL_I;
   logic [31:0] M1_ADR_I, M1_DAT_I, M1_DAT_O;
   logic        M1_WE_I, M1_STB_I, M1_CYC_I, M1_ACK_O, M1_ERR_O;
   logic [3:0]  M1_SEL_I;
   logic [31:0] S_ADR_O, S_DAT_O, S_DAT_I;
   logic        S_WE_O, S_STB_O, S_CYC_O, S_ACK_I;
   logic [3:0]  S_SEL_O;
   logic [1:0]  GNT_O;

   int pass_cnt = 0;
   int total_cnt = 0;

   uart_wb_arbiter #(.TO_W(8), .TIMEOUT(4)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_DAT_O(M0_DAT_O), .M0_WE_I(M0_WE_I),
      .M0_SEL_I(M0_SEL_I), .M0_STB_I(M0_STB_I), .M0_CYC_I(M0_CYC_I), .M0_ACK_O(M0_ACK_O),
      .M0_ERR_O(M0_ERR_O),
      .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_DAT_O(M1_DAT_O), .M1_WE_I(M1_WE_I),
      .M1_SEL_I(M1_SEL_I), .M1_STB_I(M1_STB_I), .M1_CYC_I(M1_CYC_I), .M1_ACK_O(M1_ACK_O),
      .M1_ERR_O(M1_ERR_O),
      .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I), .S_WE_O(S_WE_O),
      .S_SEL_O(S_SEL_O), .S_STB_O(S_STB_O), .S_CYC_O(S_CYC_O), .S_ACK_I(S_ACK_I),
      .GNT_O(GNT_O)
   );

   always #5 CLK_I = ~CLK_I;

   initial begin
      #200000;
      $display("FAIL sim_timeout: time limit reached");
      $fatal(1);
   end

   // Inputs change 1ns after a rising edge; outputs are sampled 1ns later
   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic clear_inputs();
      M0_ADR_I = '0; M0_DAT_I = '0; M0_WE_I = 0; M0_SEL_I = '0; M0_STB_I = 0; M0_CYC_I = 0;
      M1_ADR_I = '0; M1_DAT_I = '0; M1_WE_I = 0; M1_SEL_I = '0; M1_STB_I = 0; M1_CYC_I = 0;
      S_DAT_I = '0; S_ACK_I = 0;
   endtask

   task automatic test_reset();
      RST_I = 0;
      clear_inputs();
      #2;
      total_cnt++; if (GNT_O !== 2'b00) $display("FAIL rst_gnt: got %b want 00", GNT_O); else pass_cnt++;
      total_cnt++; if ({S_CYC_O, S_STB_O, M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O} !== 6'b0)
         $display("FAIL rst_ctl: got %b want 000000", {S_CYC_O, S_STB_O, M0_ACK_O, M1_ACK_O, M0_ERR_O, M1_ERR_O});
      else pass_cnt++;
      tick();
      RST_I = 1;
      M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h10;
      tick();
      #1;
      total_cnt++; if ({GNT_O, S_STB_O} !== 3'b011) $display("FAIL rst_pre_own: got %b want 011", {GNT_O, S_STB_O}); else pass_cnt++;
      RST_I = 0;
      #1;
      total_cnt++; if ({GNT_O, S_CYC_O, S_STB_O} !== 4'b0000)
         $display("FAIL rst_mid: got %b want 0000", {GNT_O, S_CYC_O, S_STB_O});
      else pass_cnt++;
      total_cnt++; if (S_ADR_O !== 32'h0) $display("FAIL rst_adr: got %h want 0", S_ADR_O); else pass_cnt++;
      clear_inputs();
      tick();
      RST_I = 1;
      tick();
   endtask

   task automatic test_tie_hold();
      M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = 32'h0C; M0_DAT_I = 32'h83; M0_SEL_I = 4'b0001;
      M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 1; M1_ADR_I = 32'h04; M1_DAT_I = 32'h55; M1_SEL_I = 4'b0001;
      #1;
      total_cnt++; if (GNT_O !== 2'b00) $display("FAIL tie_latency: got %b want 00", GNT_O); else pass_cnt++;
      tick();
      total_cnt++; if (GNT_O !== 2'b01) $display("FAIL tie_gnt: got %b want 01", GNT_O); else pass_cnt++;
      S_ACK_I = 1;
      #1;
      total_cnt++; if ({M0_ACK_O, M1_ACK_O, S_DAT_O[7:0]} !== {2'b10, 8'h83})
         $display("FAIL tie_beat1: got %b_%h want 10_83", {M0_ACK_O, M1_ACK_O}, S_DAT_O[7:0]);
      else pass_cnt++;
      tick();
      M0_ADR_I = 32'h00; M0_DAT_I = 32'h1B;
      #1;
      total_cnt++; if ({GNT_O, S_ADR_O[7:0], S_DAT_O[7:0]} !== {2'b01, 8'h00, 8'h1B})
         $display("FAIL tie_beat2: got %b_%h_%h want 01_00_1b", GNT_O, S_ADR_O[7:0], S_DAT_O[7:0]);
      else pass_cnt++;
      tick();
      M0_ADR_I = 32'h0C; M0_DAT_I = 32'h03;
      #1;
      total_cnt++; if ({GNT_O, S_DAT_O[7:0], M1_ACK_O} !== {2'b01, 8'h03, 1'b0})
         $display("FAIL tie_beat3: got %b_%h_%b want 01_03_0", GNT_O, S_DAT_O[7:0], M1_ACK_O);
      else pass_cnt++;
      tick();
      M0_CYC_I = 0; M0_STB_I = 0; S_ACK_I = 0;
      #1;
      total_cnt++; if (GNT_O !== 2'b01) $display("FAIL tie_drop_hold: got %b want 01", GNT_O); else pass_cnt++;
      tick();
      total_cnt++; if ({GNT_O, S_CYC_O} !== 3'b000) $display("FAIL tie_bubble: got %b want 000", {GNT_O, S_CYC_O}); else pass_cnt++;
      tick();
      total_cnt++; if ({GNT_O, S_ADR_O[7:0], S_DAT_O[7:0]} !== {2'b10, 8'h04, 8'h55})
         $display("FAIL tie_m1_gnt: got %b_%h_%h want 10_04_55", GNT_O, S_ADR_O[7:0], S_DAT_O[7:0]);
      else pass_cnt++;
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_m0_single();
      M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 1; M0_ADR_I = 32'h0C; M0_DAT_I = 32'h83; M0_SEL_I = 4'b0001;
      tick();
      total_cnt++; if ({GNT_O, S_CYC_O, S_STB_O, S_WE_O, S_SEL_O} !== {2'b01, 3'b111, 4'b0001})
         $display("FAIL m0_ctl: got %b want 011110001", {GNT_O, S_CYC_O, S_STB_O, S_WE_O, S_SEL_O});
      else pass_cnt++;
      total_cnt++; if ({S_ADR_O, S_DAT_O} !== {32'h0C, 32'h83})
         $display("FAIL m0_bus: got %h_%h want 0000000c_00000083", S_ADR_O, S_DAT_O);
      else pass_cnt++;
      total_cnt++; if (M0_ACK_O !== 1'b0) $display("FAIL m0_noack: got %b want 0", M0_ACK_O); else pass_cnt++;
      tick();
      tick();
      S_ACK_I = 1; S_DAT_I = 32'hA5;
      #1;
      total_cnt++; if ({M0_ACK_O, M1_ACK_O} !== 2'b10) $display("FAIL m0_ack: got %b want 10", {M0_ACK_O, M1_ACK_O}); else pass_cnt++;
      total_cnt++; if ({M0_DAT_O, M1_DAT_O} !== {32'hA5, 32'h0})
         $display("FAIL m0_rdat: got %h_%h want 000000a5_00000000", M0_DAT_O, M1_DAT_O);
      else pass_cnt++;
      tick();
      S_ACK_I = 0; M0_CYC_I = 0; M0_STB_I = 0;
      #1;
      total_cnt++; if (M0_ACK_O !== 1'b0) $display("FAIL m0_ack_end: got %b want 0", M0_ACK_O); else pass_cnt++;
      tick();
      total_cnt++; if (GNT_O !== 2'b00) $display("FAIL m0_release: got %b want 00", GNT_O); else pass_cnt++;
      clear_inputs();
   endtask

   // last owner is master 0 here, so the first tie goes to master 1
   task automatic test_round_robin();
      logic [1:0] exp;
      exp = 2'b10;
      M0_CYC_I = 1; M0_STB_I = 1; M1_CYC_I = 1; M1_STB_I = 1; S_ACK_I = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total_cnt++; if (GNT_O !== exp) $display("FAIL rr_gnt%0d: got %b want %b", i, GNT_O, exp); else pass_cnt++;
         if (exp == 2'b01) begin M0_CYC_I = 0; M0_STB_I = 0; end
         else              begin M1_CYC_I = 0; M1_STB_I = 0; end
         tick();
         M0_CYC_I = 1; M0_STB_I = 1; M1_CYC_I = 1; M1_STB_I = 1;
         exp = ~exp;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_timeout();
      M1_CYC_I = 1; M1_STB_I = 1; M1_ADR_I = 32'h14;
      tick();
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if ({GNT_O, S_CYC_O, S_STB_O, M1_ERR_O} !== 5'b10110)
            $display("FAIL to_wait%0d: got %b want 10110", i, {GNT_O, S_CYC_O, S_STB_O, M1_ERR_O});
         else pass_cnt++;
         if (i < 3) tick();
      end
      tick();
      total_cnt++; if ({GNT_O, S_CYC_O, S_STB_O, M1_ERR_O, M1_ACK_O, M0_ERR_O} !== 7'b1000100)
         $display("FAIL to_abort: got %b want 1000100", {GNT_O, S_CYC_O, S_STB_O, M1_ERR_O, M1_ACK_O, M0_ERR_O});
      else pass_cnt++;
      M0_CYC_I = 1; M0_STB_I = 1;
      tick();
      total_cnt++; if ({GNT_O, M1_ERR_O, S_CYC_O} !== 4'b1010)
         $display("FAIL to_hold: got %b want 1010", {GNT_O, M1_ERR_O, S_CYC_O});
      else pass_cnt++;
      M1_CYC_I = 0; M1_STB_I = 0;
      #1;
      total_cnt++; if (M1_ERR_O !== 1'b0) $display("FAIL to_err_drop: got %b want 0", M1_ERR_O); else pass_cnt++;
      tick();
      total_cnt++; if (GNT_O !== 2'b00) $display("FAIL to_idle: got %b want 00", GNT_O); else pass_cnt++;
      tick();
      total_cnt++; if ({GNT_O, S_CYC_O} !== 3'b011) $display("FAIL to_m0_gnt: got %b want 011", {GNT_O, S_CYC_O}); else pass_cnt++;
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_ack_at_limit();
      M1_CYC_I = 1; M1_STB_I = 1;
      tick();
      tick();
      tick();
      tick();
      S_ACK_I = 1; S_DAT_I = 32'h3C;
      #1;
      total_cnt++; if ({M1_ACK_O, M1_ERR_O, M1_DAT_O[7:0]} !== {2'b10, 8'h3C})
         $display("FAIL lim_ack: got %b_%h want 10_3c", {M1_ACK_O, M1_ERR_O}, M1_DAT_O[7:0]);
      else pass_cnt++;
      tick();
      S_ACK_I = 0;
      #1;
      total_cnt++; if ({GNT_O, S_CYC_O, S_STB_O, M1_ERR_O} !== 5'b10110)
         $display("FAIL lim_noabort: got %b want 10110", {GNT_O, S_CYC_O, S_STB_O, M1_ERR_O});
      else pass_cnt++;
      M1_CYC_I = 0; M1_STB_I = 0;
      tick();
      total_cnt++; if (GNT_O !== 2'b00) $display("FAIL lim_release: got %b want 00", GNT_O); else pass_cnt++;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_tie_hold();
      test_m0_single();
      test_round_robin();
      test_timeout();
      test_ack_at_limit();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
